alu_4bit: RTL and testbench

Registered 32-bit arithmetic/logic unit with a 64-bit result bus, selected by a 4-bit opcode. It covers add, subtract, full-width signed and unsigned multiply, bitwise logic, shifts, compares and optional divide. It sits in the datapath as a single-cycle-latency execution stage: operands and opcode are sampled on a clock edge, and the result appears on `out` after that edge.

---
 rtl/alu_4bit.sv | 127 ++++++++++++
 tb/tb_alu_4bit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/alu_4bit.sv
// Registered 32-bit ALU with a 64-bit result, single-cycle latency.
// Optional divide (opcodes 13/14) enabled by defining ALU_DIV_EN.
module alu_4bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  opcode,
    output logic [63:0] out
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_MULU = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_NOR  = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_SLT  = 4'd11,
        OP_SLTU = 4'd12,
        OP_DIV  = 4'd13,
        OP_DIVU = 4'd14,
        OP_PASS = 4'd15
    } op_e;

    op_e         op;
    logic [4:0]  shamt;
    logic [32:0] sum33;
    logic [32:0] diff33;
    logic [63:0] mul_s;
    logic [63:0] mul_u;
    logic [31:0] sll_r;
    logic [31:0] srl_r;
    logic [31:0] sra_r;
    logic        slt_r;
    logic        sltu_r;
    logic [63:0] divs_res;
    logic [63:0] divu_res;
    logic [63:0] res;

    assign op     = op_e'(opcode);
    assign shamt  = B[4:0];
    assign sum33  = {A[31], A} + {B[31], B};
    assign diff33 = {A[31], A} - {B[31], B};

    // Operands are widened first so the product keeps all 64 bits.
    assign mul_s = $signed({{32{A[31]}}, A})
                 * $signed({{32{B[31]}}, B});
    assign mul_u = {32'd0, A} * {32'd0, B};

    assign sll_r  = A << shamt;
    assign srl_r  = A >> shamt;
    assign sra_r  = $signed(A) >>> shamt;
    assign slt_r  = $signed(A) < $signed(B);
    assign sltu_r = A < B;

`ifdef ALU_DIV_EN
    logic               div_zero;
    logic               div_ovf;
    logic [31:0]        dvs;
    logic signed [31:0] qs;
    logic signed [31:0] rs;
    logic [31:0]        qu;
    logic [31:0]        ru;

    assign div_zero = (B == 32'd0);
    assign div_ovf  = (A == 32'h8000_0000)
                   && (B == 32'hFFFF_FFFF);

    // Corner cases divide by 1 so the divider never sees 0 or overflow.
    assign dvs = (div_zero || div_ovf) ? 32'd1 : B;
    assign qs  = $signed(A) / $signed(dvs);
    assign rs  = $signed(A) % $signed(dvs);
    assign qu  = A / dvs;
    assign ru  = A % dvs;

    always_comb begin
        divs_res = {rs, qs};
        if (div_zero)
            divs_res = {A, 32'hFFFF_FFFF};
        else if (div_ovf)
            divs_res = {32'd0, 32'h8000_0000};
    end

    assign divu_res = div_zero ? {A, 32'hFFFF_FFFF}
                               : {ru, qu};
`else
    assign divs_res = 64'd0;
    assign divu_res = 64'd0;
`endif

    always_comb begin
        res = 64'd0;
        unique case (op)
            OP_ADD:  res = {{31{sum33[32]}}, sum33};
            OP_SUB:  res = {{31{diff33[32]}}, diff33};
            OP_MUL:  res = mul_s;
            OP_MULU: res = mul_u;
            OP_AND:  res = {32'd0, A & B};
            OP_OR:   res = {32'd0, A | B};
            OP_XOR:  res = {32'd0, A ^ B};
            OP_NOR:  res = {32'd0, ~(A | B)};
            OP_SLL:  res = {32'd0, sll_r};
            OP_SRL:  res = {32'd0, srl_r};
            OP_SRA:  res = {32'd0, sra_r};
            OP_SLT:  res = {63'd0, slt_r};
            OP_SLTU: res = {63'd0, sltu_r};
            OP_DIV:  res = divs_res;
            OP_DIVU: res = divu_res;
            OP_PASS: res = {32'd0, A};
            default: res = 64'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out <= 64'd0;
        else
            out <= res;
    end

endmodule

// File: tb/tb_alu_4bit.sv
// Directed bench for alu_4bit; divide expectations follow ALU_DIV_EN.
// Inputs change #1 after the rising edge and are sampled #1 after the next.
module tb_alu_4bit;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  opcode;
    logic [63:0] out;

    int checks = 0;
    int errors = 0;

    alu_4bit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .opcode (opcode),
        .out    (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h",
                   tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0]  op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [63:0] exp,
                        input string       tag);
        opcode = op;
        A      = a;
        B      = b;
        @(posedge clk);
        #1;
        check(tag, out, exp);
    endtask

    logic [63:0] e_div;
    logic [63:0] e_divu0;
    logic [63:0] e_ovf;
    logic [63:0] e_divu;

    initial begin
`ifdef ALU_DIV_EN
        e_div   = 64'hFFFF_FFFF_FFFF_FFFD;
        e_divu0 = 64'h0000_0007_FFFF_FFFF;
        e_ovf   = 64'h0000_0000_8000_0000;
        e_divu  = 64'h0000_0002_0000_000E;
`else
        e_div   = 64'd0;
        e_divu0 = 64'd0;
        e_ovf   = 64'd0;
        e_divu  = 64'd0;
`endif
        rst_n  = 1'b1;
        A      = 32'd0;
        B      = 32'd0;
        opcode = 4'd15;
        #1 rst_n = 1'b0;
        #1 check("reset_async", out, 64'd0);
        A = 32'h1234_5678;
        @(posedge clk);
        #1 check("reset_hold", out, 64'd0);
        #2 rst_n = 1'b1;

        step(4'd1, 32'd10, 32'd5, 64'd5, "sub");
        step(4'd0, 32'h7FFF_FFFF, 32'd1,
             64'h0000_0000_8000_0000, "add_ovf");
        step(4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFE, "add_neg");
        step(4'd1, 32'h8000_0000, 32'd1,
             64'hFFFF_FFFF_7FFF_FFFF, "sub_neg");
        step(4'd4, 32'hFFFF_FFF3, 32'hFFFF_FFF1,
             64'h0000_0000_FFFF_FFF1, "and");
        step(4'd5, 32'hFFFF_FFF3, 32'hFFFF_FFF2,
             64'h0000_0000_FFFF_FFF3, "or");
        step(4'd6, 32'hFFFF_FFF3, 32'hFFFF_FFF1,
             64'h0000_0000_0000_0002, "xor");
        step(4'd7, 32'hFFFF_FFF3, 32'hFFFF_FFF1,
             64'h0000_0000_0000_000C, "nor");
        step(4'd2, 32'hFFFF_FFF3, 32'hFFFF_FFF1,
             64'd195, "mul");
        step(4'd2, 32'hFFFF_FFFF, 32'd2,
             64'hFFFF_FFFF_FFFF_FFFE, "mul_neg");
        step(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             64'hFFFF_FFFE_0000_0001, "mulu");
        step(4'd8, 32'd1, 32'd31,
             64'h0000_0000_8000_0000, "sll");
        step(4'd9, 32'h8000_0000, 32'd4,
             64'h0000_0000_0800_0000, "srl");
        step(4'd10, 32'h8000_0000, 32'd4,
             64'h0000_0000_F800_0000, "sra");
        step(4'd10, 32'h8000_0000, 32'h0000_0024,
             64'h0000_0000_F800_0000, "sra_b40");
        step(4'd11, 32'hFFFF_FFFF, 32'd1, 64'd1, "slt");
        step(4'd12, 32'hFFFF_FFFF, 32'd1, 64'd0, "sltu");
        step(4'd13, 32'hFFFF_FFF3, 32'd4, e_div, "div");
        step(4'd14, 32'd7, 32'd0, e_divu0, "divu_zero");
        step(4'd13, 32'h8000_0000, 32'hFFFF_FFFF,
             e_ovf, "div_ovf");
        step(4'd14, 32'd100, 32'd7, e_divu, "divu");
        step(4'd15, 32'hDEAD_BEEF, 32'd0,
             64'h0000_0000_DEAD_BEEF, "pass");

        A = 32'h0000_0055;
        #3 check("hold_between_edges", out,
                 64'h0000_0000_DEAD_BEEF);

        rst_n = 1'b0;
        #1 check("reset_mid", out, 64'd0);
        opcode = 4'd0;
        A      = 32'd1;
        B      = 32'd1;
        @(posedge clk);
        #1 check("reset_mid_hold", out, 64'd0);
        #2 rst_n = 1'b1;
        #1 check("reset_release", out, 64'd0);
        @(posedge clk);
        #1 check("first_capture", out, 64'd2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
